// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial WIDTH-bit adder, one full-adder slice per clock.
// Operands are taken LSB first; the carry flip-flop closes the loop between bits.

// Single-bit half-adder cell.
module serial_adder_seq_ha (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

// Full-adder slice: two half-adder cells plus an OR on their carries.
module serial_adder_seq_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    serial_adder_seq_ha u_ha0 (
        .i_x (i_a),
        .i_y (i_b),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    serial_adder_seq_ha u_ha1 (
        .i_x (w_s1),
        .i_y (i_c),
        .o_s (o_s),
        .o_c (w_c2)
    );

    assign o_c = w_c1 | w_c2;
endmodule

module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic             w_sbit;
    logic             w_cnext;
    logic [WIDTH-1:0] w_result_nxt;

    serial_adder_seq_fa u_fa (
        .i_a (r_op_a[0]),
        .i_b (r_op_b[0]),
        .i_c (r_carry),
        .o_s (w_sbit),
        .o_c (w_cnext)
    );

    // New sum bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_result_nxt = w_sbit;
        end else begin : g_wn
            assign w_result_nxt = {w_sbit, r_result[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM and datapath: accept, shift one bit per edge, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op_a   <= a;
                        r_op_b   <= b;
                        r_carry  <= cin;
                        r_result <= '0;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry  <= w_cnext;
                    r_result <= w_result_nxt;
                    r_op_a   <= r_op_a >> 1;
                    r_op_b   <= r_op_b >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_sum       <= w_result_nxt;
                        r_cout      <= w_cnext;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_sum       <= '0;
                        r_cout      <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Acceptance is blocked for the whole cycle in which reset is held.
    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed and randomized checks of serial_adder_seq
// at WIDTH=8 and WIDTH=1 against a plain a+b+cin reference.

module tb_serial_adder_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    logic       ir8, ov8, co8, bz8;
    logic [7:0] s8;
    logic       ir1, ov1, co1, bz1;
    logic [0:0] s1;

    logic       ir_m, ov_m, bz_m;
    logic [8:0] res_m;

    int errors = 0;
    int checks = 0;
    int ecnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    serial_adder_seq #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (ir8),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (ov8),
        .out_ready (out_ready & ~sel),
        .sum       (s8),
        .cout      (co8),
        .busy      (bz8)
    );

    serial_adder_seq #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (ir1),
        .a         (a[0:0]),
        .b         (b[0:0]),
        .cin       (cin),
        .out_valid (ov1),
        .out_ready (out_ready & sel),
        .sum       (s1),
        .cout      (co1),
        .busy      (bz1)
    );

    assign ir_m  = sel ? ir1 : ir8;
    assign ov_m  = sel ? ov1 : ov8;
    assign bz_m  = sel ? bz1 : bz8;
    assign res_m = sel ? {7'b0, co1, s1} : {co8, s8};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Issue one WIDTH=8 operation from IDLE and wait (bounded) for out_valid.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, output logic [8:0] res,
                          output int lat, output logic busy_ok);
        int acc;
        a = ta;
        b = tb;
        cin = tc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        acc = ecnt;
        busy_ok = bz_m;
        for (int n = 0; n < 40 && !ov_m; n++) begin
            @(negedge clk);
            busy_ok = busy_ok & bz_m;
        end
        if (!ov_m) chk("timeout", 0, 1);
        lat = ecnt - acc;
        res = res_m;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic rand_phase(input logic w_sel, input int nops);
        logic [8:0] q[$];
        logic [8:0] e;
        logic [8:0] prev_res;
        logic       prev_ov;
        logic       prev_or;
        int w;
        int acc_n;
        int res_n;
        int last_acc;
        int acc_edge;
        int cyc;
        sel = w_sel;
        w = w_sel ? 1 : 8;
        acc_n = 0;
        res_n = 0;
        last_acc = 0;
        acc_edge = 0;
        cyc = 0;
        prev_ov = 1'b0;
        prev_or = 1'b0;
        prev_res = '0;
        while (res_n < nops && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (ov_m && !prev_ov) chk("latency", 64'(ecnt - acc_edge), 64'(w));
            if (prev_ov && !prev_or) begin
                chk("hold_valid", ov_m, 1);
                chk("hold_data", res_m, prev_res);
            end
            if (ov_m) chk("ready_in_done", ir_m, 0);
            in_valid = (acc_n < nops) && ($urandom_range(1, 0) == 1);
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            out_ready = ($urandom_range(2, 0) != 0);
            if (in_valid && ir_m) begin
                if (w_sel) e = 9'(a[0]) + 9'(b[0]) + 9'(cin);
                else       e = 9'(a) + 9'(b) + 9'(cin);
                q.push_back(e);
                if (acc_n > 0)
                    chk("interval", 64'((ecnt + 1 - last_acc) >= w + 2), 1);
                last_acc = ecnt + 1;
                acc_edge = ecnt + 1;
                acc_n++;
            end
            if (ov_m && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk(w_sel ? "sum_w1" : "sum_w8", res_m, e);
                end
                res_n++;
            end
            prev_ov = ov_m;
            prev_res = res_m;
            prev_or = out_ready;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("count", res_n, acc_n);
        chk("ops_done", res_n, nops);
    endtask

    initial begin
        logic [8:0] res;
        logic       bok;
        logic       seen;
        int         lat;

        rst = 1'b1;
        sel = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", ir_m, 0);
        chk("rst_out_valid", ov_m, 0);
        chk("rst_sum", res_m, 0);
        chk("rst_busy", bz_m, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ir_m, 1);

        run_op(8'h5A, 8'h3C, 1'b0, res, lat, bok);
        chk("lat_5a", lat, 8);
        chk("sum_5a", res, 9'h096);
        chk("busy_5a", bok, 1);
        take_result();
        chk("idle_ready", ir_m, 1);
        chk("idle_busy", bz_m, 0);
        chk("idle_valid", ov_m, 0);

        run_op(8'hFF, 8'h01, 1'b0, res, lat, bok);
        chk("sum_ff01", res, 9'h100);
        take_result();
        run_op(8'hFF, 8'hFF, 1'b1, res, lat, bok);
        chk("sum_ffff1", res, 9'h1FF);
        take_result();

        run_op(8'h12, 8'h34, 1'b1, res, lat, bok);
        chk("sum_bp", res, 9'h047);
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b1;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", ov_m, 1);
            chk("bp_data", res_m, 9'h047);
            chk("bp_ready", ir_m, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_not_taken", bz_m, 0);
        chk("bp_ready_after", ir_m, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept", bz_m, 1);
        for (int n = 0; n < 40 && !ov_m; n++) @(negedge clk);
        chk("sum_aa55", res_m, 9'h100);
        take_result();

        a = 8'h77;
        b = 8'h11;
        cin = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", ov_m, 0);
        chk("abort_sum", res_m, 0);
        chk("abort_busy", bz_m, 0);
        chk("abort_ready", ir_m, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", ir_m, 1);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | ov_m | bz_m;
        end
        out_ready = 1'b0;
        chk("abort_no_result", seen, 0);

        rand_phase(1'b0, 1000);
        rand_phase(1'b1, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
